// File: rtl/shift_serializer_ctrl.sv
// rtl/shift_serializer_ctrl.sv - word-to-serial control stage driving an external Reg_Shift
// Loads a word into Reg_Shift, then shifts it out one bit per accepted ser_ready cycle.

module shift_serializer_ctrl #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] in_data,
   input  logic         in_dir,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         ser_ready,
   output logic         ser_bit,
   output logic         ser_valid,
   output logic         ser_last,
   output logic         busy,
   output logic         sr_reset,
   output logic         sr_ps_select,
   output logic         sr_lr_select,
   output logic [W-1:0] sr_data,
   output logic         sr_input_left,
   output logic         sr_input_right,
   input  logic [W-1:0] sr_out
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]    r_state;
   logic          r_dir;
   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last         = (r_state == S_SHIFT) && (r_cnt == LAST_CNT);
   assign sr_reset       = reset;
   assign sr_input_left  = 1'b0;
   assign sr_input_right = 1'b0;

   always_comb begin
      in_ready     = 1'b0;
      busy         = 1'b0;
      ser_valid    = 1'b0;
      ser_last     = 1'b0;
      ser_bit      = 1'b0;
      sr_ps_select = 1'b0;
      sr_lr_select = r_dir;
      sr_data      = sr_out;
      if (reset) begin
         sr_lr_select = 1'b0;
      end else if (r_state == S_IDLE) begin
         // Reg_Shift loads every idle cycle; only the accepted word matters.
         in_ready     = 1'b1;
         sr_ps_select = 1'b1;
         sr_data      = in_data;
         sr_lr_select = in_dir;
      end else begin
         busy      = 1'b1;
         ser_valid = 1'b1;
         ser_last  = w_last;
         ser_bit   = r_dir ? sr_out[W-1] : sr_out[0];
         if (!ser_ready) begin
            // Stall: reload the register with its own contents so ser_bit holds.
            sr_ps_select = 1'b1;
            sr_data      = sr_out;
         end else if (w_last) begin
            in_ready = 1'b1;
            if (in_valid) begin
               sr_ps_select = 1'b1;
               sr_data      = in_data;
               sr_lr_select = in_dir;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_dir   <= 1'b0;
         r_cnt   <= '0;
      end else if (r_state == S_IDLE) begin
         if (in_valid) begin
            r_state <= S_SHIFT;
            r_dir   <= in_dir;
            r_cnt   <= '0;
         end
      end else if (ser_ready) begin
         if (!w_last) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (in_valid) begin
            r_dir <= in_dir;
            r_cnt <= '0;
         end else begin
            r_state <= S_IDLE;
         end
      end
   end

endmodule

// File: doc/shift_serializer_ctrl.md
# shift_serializer_ctrl

Upstream control stage for `Reg_Shift`. It accepts W-bit words over a valid/ready handshake, parallel-loads each word into `Reg_Shift`, then drives `Reg_Shift` in shift mode for W cycles. While shifting, it taps the departing end of `Reg_Shift`'s `out` bus and presents the word as a serial bit stream with its own valid/ready handshake. The block owns every control input of `Reg_Shift`; `Reg_Shift` itself is unchanged.

## Interface
- W, 5, word width; must match `Reg_Shift` W; W >= 2
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the rising edge where sampled high
- in_data  in  W  word to serialize
- in_dir  in  1  1 = MSB-first (left shift), 0 = LSB-first (right shift); sampled with in_data
- in_valid  in  1  in_data/in_dir valid
- in_ready  out  1  block can accept a word this cycle
- ser_ready  in  1  downstream consumes ser_bit this cycle
- ser_bit  out  1  current serial bit
- ser_valid  out  1  ser_bit valid
- ser_last  out  1  ser_bit is bit W-1 of the current word
- busy  out  1  word in flight
- sr_reset  out  1  to `Reg_Shift` reset
- sr_ps_select  out  1  to `Reg_Shift` ps_select; 1 = parallel load, 0 = shift
- sr_lr_select  out  1  to `Reg_Shift` lr_select; 1 = left, 0 = right
- sr_data  out  W  to `Reg_Shift` data
- sr_input_left  out  1  to `Reg_Shift` input_left; fill bit for right shift
- sr_input_right  out  1  to `Reg_Shift` input_right; fill bit for left shift
- sr_out  in  W  from `Reg_Shift` out

## Operation
- `sr_reset` = `reset`, combinational pass-through.
- `sr_input_left` and `sr_input_right` are tied to 0.
- Registered state:
  - `state`: IDLE or SHIFT
  - `dir`: 1 bit
  - `cnt`: 0..W-1, width clog2(W)
- IDLE:
  - `in_ready`=1, `busy`=0, `ser_valid`=0.
  - `sr_ps_select`=1 and `sr_data`=`in_data`, so `Reg_Shift` loads every cycle; only an accepted word matters.
  - On `in_valid`: latch `dir`<=`in_dir`, `cnt`<=0, go to SHIFT. The load happens on the same edge.
- SHIFT:
  - `busy`=1, `ser_valid`=1.
  - `ser_bit` = `dir` ? `sr_out[W-1]` : `sr_out[0]`.
  - `sr_lr_select`=`dir`.
  - `ser_last` = (`cnt`==W-1).
- SHIFT, `ser_ready`=1 and not last:
  - `sr_ps_select`=0, so `Reg_Shift` shifts.
  - `cnt`<=`cnt`+1.
- SHIFT, `ser_ready`=0 (stall):
  - `sr_ps_select`=1 and `sr_data`=`sr_out`, so `Reg_Shift` reloads itself and holds.
  - `cnt`, `dir` and `state` hold.
  - `ser_bit` is stable for the whole stall.
- SHIFT, `ser_ready`=1 and `ser_last`:
  - `in_ready`=1 in this cycle, giving a back-to-back path.
  - If `in_valid`: `sr_ps_select`=1, `sr_data`=`in_data`, latch the new `dir`, `cnt`<=0, stay in SHIFT.
  - Otherwise: go to IDLE. `Reg_Shift` contents are don't-care.
- `in_ready`=0 in all other SHIFT cycles.
- `sr_lr_select` is don't-care during a load; drive `in_dir` in IDLE for determinism.
- Reset value while `reset`=1, with state IDLE taking effect on the next cycle:
  - Held at 0 during the reset cycle: `in_ready`, `ser_valid`, `ser_last`, `busy`.
  - `cnt`=0, `dir`=0.
  - `sr_ps_select`=0.
  - `sr_reset`=1.

## Timing
- Word accepted at edge t, where `in_valid`&`in_ready` is sampled.
- Bit 0 appears in cycle t+1. Latency from acceptance to first `ser_valid` is one cycle.
- With `ser_ready` held high, bits appear in cycles t+1..t+W, with `ser_last` in cycle t+W.
- Sustained throughput is one word per W cycles, with no bubble when the next word waits.
- Each stall cycle adds exactly one cycle and loses no bit.
- Reset mid-word:
  - The word is dropped.
  - `ser_valid`=0 starting in the reset cycle.
  - `Reg_Shift` clears on the same edge.
  - No partial bits appear after reset.
- `in_valid` in SHIFT outside the last-bit cycle is ignored (`in_ready`=0). The upstream source must hold it.

## Test plan
- W=5; reset 2 cycles; `in_data`=10110, `in_dir`=1, `ser_ready`=1 -> `ser_bit` 1,0,1,1,0 in cycles t+1..t+5; `ser_last` only at t+5; `busy` 1 for 5 cycles; then IDLE with `in_ready`=1.
- `in_data`=10110, `in_dir`=0 -> `ser_bit` 0,1,1,0,1; `sr_lr_select`=0 during shifts.
- MSB-first 11001; `ser_ready`=0 for 3 cycles after bit 1 -> `ser_bit` held 1 for 3 cycles; total stream 1,1,0,0,1 over 8 cycles; `sr_out` unchanged during the stall.
- Back-to-back: 10000 (dir=1), then 00011 (dir=0) with `in_valid` high in the `ser_last` cycle -> 10 contiguous valid bits 1,0,0,0,0,1,1,0,0,0; no gap.
- `reset` pulsed at bit 3 of 11111 -> `ser_valid`=0 from the reset cycle; `sr_out`=00000 after the edge; next word 01010 (dir=1) streams 0,1,0,1,0 cleanly.
- Bench instantiates `Reg_Shift` plus the block and compares `ser_bit` against a reference model for 100 random words, dirs and stall patterns.
